systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default 2: systolic array dimension (N x N PEs), range 2..4.
REQ-002 Parameter K, default 4: inner dimension (A is N x K, B is K x N), range 1..16.
REQ-003 Parameter DRAIN, default 2*N+2: wait cycles after feed for the array to settle.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ld_en  in  1  operand write strobe; ld_sel in 1 (0=A, 1=B); ld_addr in clog2(N*K); ld_data in 8 signed.
REQ-007 start  in  1  begin one matrix multiply; busy out 1; done out 1 (one-cycle pulse).
REQ-008 arr_clear out 1 (array reset pulse); arr_valid out 1 (array valid); a_edge out N*8 (row i at bits [8i+7:8i]); b_edge out N*8 (column j likewise).
REQ-009 y_in  in  N*N*32  array results, PE (i,j) at index i*N+j; ovf_in in N*N  per-PE overflow.
REQ-010 res_valid out 1; res_ready in 1; res_data out 32 signed; res_idx out clog2(N*N); ovf out 1.

Function
REQ-011 FSM states IDLE, CLEAR, FEED, DRAIN, READ; busy=1 in every state except IDLE.
REQ-012 Buffers: A row-major (addr=i*K+k), B row-major (addr=k*N+j); ld_en writes only in IDLE, ignored elsewhere; addr >= N*K ignored.
REQ-013 IDLE + start -> CLEAR; start in any other state ignored; simultaneous ld_en and start in IDLE: write performed, then CLEAR.
REQ-014 CLEAR lasts exactly 1 cycle with arr_clear=1; arr_clear=0 in all other states.
REQ-015 FEED lasts K+N-1 cycles, counter t=0..K+N-2, arr_valid=1 throughout, 0 elsewhere.
REQ-016 FEED skew: a_edge row i = A[i][t-i] if 0<=t-i<K else 0; b_edge col j = B[t-j][j] if 0<=t-j<K else 0; edges are 0 outside FEED.
REQ-017 DRAIN lasts DRAIN cycles; on its last cycle y_in is captured into N*N internal result registers.
REQ-018 READ: res_valid=1, res_data=captured result[res_idx], res_idx starts 0, increments on res_valid&&res_ready.
REQ-019 Handshake at res_idx=N*N-1 -> IDLE; done=1 on the following cycle (first IDLE cycle) only.
REQ-020 res_data/res_idx hold stable while res_valid=1 and res_ready=0; res_valid=0 outside READ.
REQ-021 Operand buffers keep contents across operations; repeated start reuses them.

Reset
REQ-022 reset forces IDLE regardless of state, including mid-FEED/READ, and takes priority over start and ld_en.
REQ-023 Reset values: busy=0, done=0, arr_clear=0, arr_valid=0, a_edge=0, b_edge=0, res_valid=0, res_idx=0, res_data=0, ovf=0; buffers and result registers = 0.

Configuration
REQ-024 Macro SYSTOLIC_CTRL_OVF_STICKY_EN defined: ovf is set when any ovf_in bit is 1 during FEED or DRAIN, holds until the next CLEAR (cleared there) or reset.
REQ-025 Macro undefined: ovf is constant 0 and no overflow logic is built; all other behaviour identical.

Verification
REQ-026 N=2,K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], behavioural array, res_ready=1 -> results idx0..3 = 19,22,43,50, done pulse once.
REQ-027 Skew check same load: FEED t=0 a_edge={0,1}, b_edge={0,5}; t=1 a_edge row0=2,row1=3, b_edge col0=7,col1=6; t=2 a_edge row1=4, b_edge col1=8.
REQ-028 res_ready toggled 1,0,0,1,... -> res_idx/res_data stable during stalls, each result emitted exactly once, in order 0..3.
REQ-029 reset asserted at FEED t=1 -> next cycle state IDLE, arr_valid=0, busy=0, no done; subsequent start completes normally with buffers zeroed (all results 0).
REQ-030 With macro: ovf_in[2]=1 for one DRAIN cycle -> ovf=1 through READ, cleared in next CLEAR; without macro ovf stays 0.
REQ-031 ld_en with ld_data=9 during FEED and start during READ -> both ignored; results unchanged, no extra operation.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: host bus for operand loading, start/done and result streaming.
interface systolic_ctrl_if #(parameter int N = 2, parameter int K = 4);
   logic ld_en;
   logic ld_sel;
   logic [$clog2(N*K)-1:0] ld_addr;
   logic signed [7:0] ld_data;
   logic start;
   logic busy;
   logic done;
   logic res_valid;
   logic res_ready;
   logic signed [31:0] res_data;
   logic [$clog2(N*N)-1:0] res_idx;
   logic ovf;
   modport master (output ld_en, ld_sel, ld_addr, ld_data, start, res_ready,
                   input busy, done, res_valid, res_data, res_idx, ovf);
   modport slave (input ld_en, ld_sel, ld_addr, ld_data, start, res_ready,
                  output busy, done, res_valid, res_data, res_idx, ovf);
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences clear/skewed feed/drain/readout for an N x N systolic array.
// Define SYSTOLIC_CTRL_OVF_STICKY_EN to build the sticky overflow flag.
module systolic_ctrl #(
   parameter int N = 2,
   parameter int K = 4,
   parameter int DRAIN = 2*N+2
) (
   input logic clk,
   input logic reset,
   systolic_ctrl_if.slave bus,
   output logic arr_clear,
   output logic arr_valid,
   output logic [N*8-1:0] a_edge,
   output logic [N*8-1:0] b_edge,
   input logic [N*N*32-1:0] y_in,
   input logic [N*N-1:0] ovf_in
);
   localparam int IW = $clog2(N*N);
   localparam int CW = $clog2(K+N+DRAIN);
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READ} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic signed [7:0] a_buf [N*K];
   logic signed [7:0] b_buf [N*K];
   logic signed [31:0] res [N*N];
   logic done_q;
   logic last_feed, last_drain, hs_last;
   assign last_feed = cnt == CW'(K+N-2);
   assign last_drain = cnt == CW'(DRAIN-1);
   assign hs_last = bus.res_ready && idx == IW'(N*N-1);
   assign bus.busy = state != S_IDLE;
   assign bus.done = done_q;
   assign bus.res_valid = state == S_READ;
   assign bus.res_idx = idx;
   assign bus.res_data = state == S_READ ? res[idx] : '0;
   assign arr_clear = state == S_CLEAR;
   assign arr_valid = state == S_FEED;
   always_comb begin
      state_n = state == S_IDLE  ? (bus.start ? S_CLEAR : S_IDLE)
              : state == S_CLEAR ? S_FEED
              : state == S_FEED  ? (last_feed ? S_DRAIN : S_FEED)
              : state == S_DRAIN ? (last_drain ? S_READ : S_DRAIN)
              : hs_last ? S_IDLE : S_READ;
   end
   // Row i / column j see operand k on feed cycle t = i+k / j+k.
   always_comb begin
      a_edge = '0;
      b_edge = '0;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++)
            if (state == S_FEED && cnt == CW'(i+k)) begin
               a_edge[8*i +: 8] = a_buf[i*K+k];
               b_edge[8*i +: 8] = b_buf[k*N+i];
            end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt <= '0;
         idx <= '0;
         done_q <= 1'b0;
         for (int p = 0; p < N*N; p++) res[p] <= '0;
         for (int p = 0; p < N*K; p++) begin
            a_buf[p] <= '0;
            b_buf[p] <= '0;
         end
      end else begin
         state <= state_n;
         cnt <= state_n != state ? '0 : cnt + 1'b1;
         done_q <= state == S_READ && hs_last;
         if (state == S_READ && bus.res_ready) idx <= hs_last ? '0 : idx + 1'b1;
         if (state == S_IDLE && bus.ld_en && int'(bus.ld_addr) < N*K) begin
            if (bus.ld_sel) b_buf[bus.ld_addr] <= bus.ld_data;
            else a_buf[bus.ld_addr] <= bus.ld_data;
         end
         if (state == S_DRAIN && last_drain)
            for (int p = 0; p < N*N; p++) res[p] <= signed'(y_in[32*p +: 32]);
      end
   end
`ifdef SYSTOLIC_CTRL_OVF_STICKY_EN
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (reset || state == S_CLEAR) ovf_q <= 1'b0;
      else if ((state == S_FEED || state == S_DRAIN) && |ovf_in) ovf_q <= 1'b1;
   end
   assign bus.ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ^ovf_in;
   assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed checks of systolic_ctrl against a behavioural 2x2 array.
module tb_systolic_ctrl;
   localparam int N = 2;
   localparam int K = 2;
`ifdef SYSTOLIC_CTRL_OVF_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset;
   logic arr_clear, arr_valid;
   logic [N*8-1:0] a_edge, b_edge;
   logic [N*N*32-1:0] y_in;
   logic [N*N-1:0] ovf_in;
   int vecs = 0;
   int errs = 0;
   int exp_r [4] = '{19, 22, 43, 50};
   always #5 clk = ~clk;
   systolic_ctrl_if #(.N(N), .K(K)) bus ();
   systolic_ctrl #(.N(N), .K(K)) dut (
      .clk(clk), .reset(reset), .bus(bus), .arr_clear(arr_clear), .arr_valid(arr_valid),
      .a_edge(a_edge), .b_edge(b_edge), .y_in(y_in), .ovf_in(ovf_in));
   // Behavioural array: a moves right, b moves down, each PE accumulates a*b.
   logic signed [7:0] ar [N][N], br [N][N], ain [N][N], bin [N][N];
   logic signed [31:0] acc [N][N];
   always_comb begin
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ain[i][j] = j == 0 ? signed'(a_edge[8*i +: 8]) : ar[i][(j+N-1)%N];
            bin[i][j] = i == 0 ? signed'(b_edge[8*j +: 8]) : br[(i+N-1)%N][j];
            y_in[32*(i*N+j) +: 32] = acc[i][j];
         end
   end
   always @(posedge clk)
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (reset || arr_clear) begin
               ar[i][j] <= '0;
               br[i][j] <= '0;
               acc[i][j] <= '0;
            end else begin
               ar[i][j] <= ain[i][j];
               br[i][j] <= bin[i][j];
               acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
            end
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic load(input bit sel, input int addr, input int d, input bit with_start);
      bus.ld_en = 1'b1;
      bus.ld_sel = sel;
      bus.ld_addr = 2'(addr);
      bus.ld_data = 8'(d);
      bus.start = with_start;
      tick();
      bus.ld_en = 1'b0;
      bus.start = 1'b0;
   endtask
   task automatic load_all(input bit start_on_last);
      for (int p = 0; p < 4; p++) load(1'b0, p, p + 1, 1'b0);
      for (int p = 0; p < 4; p++) load(1'b1, p, p + 5, start_on_last && p == 3);
   endtask
   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask
   task automatic wait_read();
      for (int c = 0; c < 40 && !bus.res_valid; c++) tick();
      vecs++;
      if (bus.res_valid !== 1'b1) begin
         errs++;
         $display("FAIL wait_read: res_valid=%b required 1", bus.res_valid);
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      bus.ld_en = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
      bus.start = 1'b0; bus.res_ready = 1'b0; ovf_in = '0;
      tick(); tick();
      reset = 1'b0;
      vecs++;
      if ({bus.busy, bus.done, arr_clear, arr_valid, bus.res_valid, bus.ovf} !== 6'b0) begin
         errs++;
         $display("FAIL reset_flags: busy/done/clr/vld/rvld/ovf=%b required 000000",
                  {bus.busy, bus.done, arr_clear, arr_valid, bus.res_valid, bus.ovf});
      end
      vecs++;
      if ({a_edge, b_edge} !== 32'h0) begin
         errs++;
         $display("FAIL reset_edges: a_edge=%h b_edge=%h required 0000 0000", a_edge, b_edge);
      end
      vecs++;
      if (bus.res_idx !== 2'd0 || bus.res_data !== 32'sd0) begin
         errs++;
         $display("FAIL reset_res: idx=%0d data=%0d required 0 0", bus.res_idx, bus.res_data);
      end
   endtask
   task automatic test_skew();
      logic [15:0] ea [3] = '{16'h0001, 16'h0302, 16'h0400};
      logic [15:0] eb [3] = '{16'h0005, 16'h0607, 16'h0800};
      load_all(1'b0);
      pulse_start();
      vecs++;
      if (arr_clear !== 1'b1 || bus.busy !== 1'b1 || arr_valid !== 1'b0) begin
         errs++;
         $display("FAIL clear_state: arr_clear=%b busy=%b arr_valid=%b required 1 1 0",
                  arr_clear, bus.busy, arr_valid);
      end
      for (int t = 0; t < 3; t++) begin
         tick();
         vecs++;
         if (arr_valid !== 1'b1 || arr_clear !== 1'b0 || a_edge !== ea[t] || b_edge !== eb[t]) begin
            errs++;
            $display("FAIL skew_t%0d: valid=%b clr=%b a_edge=%h b_edge=%h required 1 0 %h %h",
                     t, arr_valid, arr_clear, a_edge, b_edge, ea[t], eb[t]);
         end
      end
      tick();
      vecs++;
      if (arr_valid !== 1'b0 || a_edge !== 16'h0 || b_edge !== 16'h0 || bus.busy !== 1'b1) begin
         errs++;
         $display("FAIL drain_edges: valid=%b a_edge=%h b_edge=%h busy=%b required 0 0000 0000 1",
                  arr_valid, a_edge, b_edge, bus.busy);
      end
   endtask
   task automatic test_results();
      int n = 0;
      wait_read();
      bus.res_ready = 1'b1;
      for (int c = 0; c < 20 && n < 4; c++) begin
         vecs++;
         if (bus.res_valid !== 1'b1 || bus.res_idx !== 2'(n) || bus.res_data !== exp_r[n]) begin
            errs++;
            $display("FAIL result_%0d: valid=%b idx=%0d data=%0d required 1 %0d %0d",
                     n, bus.res_valid, bus.res_idx, bus.res_data, n, exp_r[n]);
         end
         n++;
         tick();
      end
      bus.res_ready = 1'b0;
      vecs++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
         errs++;
         $display("FAIL done_pulse: done=%b busy=%b res_valid=%b required 1 0 0",
                  bus.done, bus.busy, bus.res_valid);
      end
      tick();
      vecs++;
      if (bus.done !== 1'b0) begin
         errs++;
         $display("FAIL done_width: done=%b required 0", bus.done);
      end
   endtask
   task automatic test_stall();
      logic [3:0] pat = 4'b1001;
      int n = 0;
      pulse_start();
      wait_read();
      for (int c = 0; c < 40 && n < 4; c++) begin
         bus.res_ready = pat[c%4];
         vecs++;
         if (bus.res_valid !== 1'b1 || bus.res_idx !== 2'(n) || bus.res_data !== exp_r[n]) begin
            errs++;
            $display("FAIL stall_c%0d: valid=%b idx=%0d data=%0d required 1 %0d %0d",
                     c, bus.res_valid, bus.res_idx, bus.res_data, n, exp_r[n]);
         end
         tick();
         if (bus.res_ready) n++;
      end
      bus.res_ready = 1'b0;
      vecs++;
      if (n !== 4 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         errs++;
         $display("FAIL stall_end: count=%0d done=%b busy=%b required 4 1 0", n, bus.done, bus.busy);
      end
   endtask
   task automatic test_reset_mid_feed();
      int n = 0;
      int dones = 0;
      pulse_start();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vecs++;
      if (bus.busy !== 1'b0 || arr_valid !== 1'b0 || bus.done !== 1'b0) begin
         errs++;
         $display("FAIL mid_reset: busy=%b arr_valid=%b done=%b required 0 0 0",
                  bus.busy, arr_valid, bus.done);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         dones += int'(bus.done);
      end
      vecs++;
      if (dones !== 0) begin
         errs++;
         $display("FAIL mid_reset_done: done pulses=%0d required 0", dones);
      end
      pulse_start();
      wait_read();
      bus.res_ready = 1'b1;
      for (int c = 0; c < 20 && n < 4; c++) begin
         vecs++;
         if (bus.res_idx !== 2'(n) || bus.res_data !== 32'sd0) begin
            errs++;
            $display("FAIL zero_result_%0d: idx=%0d data=%0d required %0d 0",
                     n, bus.res_idx, bus.res_data, n);
         end
         n++;
         tick();
      end
      bus.res_ready = 1'b0;
      vecs++;
      if (bus.done !== 1'b1) begin
         errs++;
         $display("FAIL zero_done: done=%b required 1", bus.done);
      end
   endtask
   task automatic test_ignored();
      int n = 0;
      int busy_seen = 0;
      load_all(1'b1);
      vecs++;
      if (arr_clear !== 1'b1) begin
         errs++;
         $display("FAIL load_and_start: arr_clear=%b required 1", arr_clear);
      end
      tick();
      load(1'b0, 0, 9, 1'b0);
      wait_read();
      bus.res_ready = 1'b1;
      for (int c = 0; c < 20 && n < 4; c++) begin
         bus.start = 1'b1;
         vecs++;
         if (bus.res_idx !== 2'(n) || bus.res_data !== exp_r[n]) begin
            errs++;
            $display("FAIL ignored_result_%0d: idx=%0d data=%0d required %0d %0d",
                     n, bus.res_idx, bus.res_data, n, exp_r[n]);
         end
         n++;
         tick();
      end
      bus.start = 1'b0;
      bus.res_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         busy_seen += int'(bus.busy);
         tick();
      end
      vecs++;
      if (busy_seen !== 0) begin
         errs++;
         $display("FAIL no_extra_op: busy cycles=%0d required 0", busy_seen);
      end
   endtask
   task automatic test_ovf();
      pulse_start();
      for (int c = 0; c < 4; c++) tick();
      ovf_in = 4'b0100;
      tick();
      ovf_in = '0;
      vecs++;
      if (bus.ovf !== STICKY) begin
         errs++;
         $display("FAIL ovf_set: ovf=%b required %b", bus.ovf, STICKY);
      end
      wait_read();
      vecs++;
      if (bus.ovf !== STICKY) begin
         errs++;
         $display("FAIL ovf_read: ovf=%b required %b", bus.ovf, STICKY);
      end
      bus.res_ready = 1'b1;
      for (int c = 0; c < 20 && bus.busy; c++) tick();
      bus.res_ready = 1'b0;
      vecs++;
      if (bus.ovf !== STICKY || bus.busy !== 1'b0) begin
         errs++;
         $display("FAIL ovf_idle: ovf=%b busy=%b required %b 0", bus.ovf, bus.busy, STICKY);
      end
      pulse_start();
      tick();
      vecs++;
      if (bus.ovf !== 1'b0) begin
         errs++;
         $display("FAIL ovf_cleared: ovf=%b required 0", bus.ovf);
      end
      wait_read();
      bus.res_ready = 1'b1;
      for (int c = 0; c < 20 && bus.busy; c++) tick();
      bus.res_ready = 1'b0;
   endtask
   initial begin
      test_reset();
      test_skew();
      test_results();
      test_stall();
      test_reset_mid_feed();
      test_ignored();
      test_ovf();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
